config_uart_tx: RTL
===================

# config_uart_tx

Transmit-side counterpart of the configuration UART loader. It serialises a complete configuration frame onto a UART line: ID header 0x00 0xAA 0xFF, a command byte, then a caller-supplied number of 32-bit words, sent either as raw binary bytes or as ASCII-hex characters. It is used for board-to-board bitstream forwarding and as the loopback stimulus source for the loader. It also produces the same 20-bit additive data checksum that the loader computes.

## Interface
- ComRate, 217, clocks per UART bit (f_CLK / baud); legal range 4..65535.
- CLK  in  1  system clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- Start  in  1  frame request; sampled only in Idle.
- Command  in  8  command byte, latched when Start is accepted; bit 7 = 1 selects hex encoding, bit 7 = 0 selects binary.
- WordCount  in  16  number of data words in the frame, latched when Start is accepted; 0 = header and command only.
- WriteData  in  32  next data word.
- WriteValid  in  1  WriteData is valid.
- WriteReady  out  1  block accepts a word this cycle.
- Tx  out  1  serial line; idles high.
- Busy  out  1  frame in progress.
- Done  out  1  one-cycle pulse at frame end.
- Checksum  out  20  modulo-2^20 sum of the data bytes sent in the current or last frame.

## Operation
- Character format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity.
- Each bit is held for exactly ComRate clocks. The bit timer is a 16-bit down-counter.
- Frame FSM states: Idle -> SendID0 -> SendIDAA -> SendIDFF -> SendCmd -> (WordCount=0 ? Finish : WaitWord) -> SendWord -> (words left ? WaitWord : Finish) -> Idle.
- Idle:
  - Tx=1, Busy=0.
  - Start=1 latches Command and WordCount, clears Checksum, and enters SendID0.
- WaitWord:
  - WriteReady=1, Tx=1.
  - The handshake fires when WriteValid and WriteReady are both 1. The word is latched, the remaining-word counter decrements, and the state moves to SendWord.
- SendWord byte order: [31:24], [23:16], [15:8], [7:0].
  - Binary mode: 4 characters per word, each the raw byte.
  - Hex mode: 8 characters per word, high nibble first. Nibbles map to 0x30-0x39 for 0-9 and 0x41-0x46 for A-F (uppercase only).
- Checksum: each data byte is added once, in both modes, when its last character's stop bit completes. Wraps modulo 2^20. Header and command bytes are excluded.
- Finish:
  - Done=1 for one cycle, Busy falls, and the state returns to Idle.
  - Checksum holds its value until the next accepted Start.
- Start is ignored outside Idle. WriteValid is ignored outside WaitWord.
- Reset mid-operation: all state is cleared immediately and Tx is forced to 1. A partial character is abandoned. No Done pulse is generated.

## Timing
- Reset values: Tx=1, Busy=0, Done=0, WriteReady=0, Checksum=0. FSM=Idle.
- All outputs are registered.
- Start sampled high at edge N:
  - Busy=1 and Tx=0 (start bit of 0x00) from cycle N+1.
- Characters within the header run back-to-back, 10*ComRate clocks each, with no idle gap.
- After the stop bit of the command byte or of a word's last character:
  - If words remain, WriteReady=1 on the next cycle.
  - A word accepted at edge M drives the start bit of its first character from cycle M+1.
  - WriteReady is 0 from cycle M+1.
- Minimum word-to-word gap on Tx is 1 idle-high cycle, the handshake cycle. Tx stays high indefinitely while WriteValid=0.
- Done asserts on the cycle after the final stop bit's last clock. Busy=0 on the same cycle.
- Start-to-Done latency with WordCount=W and zero-wait handshakes:
  - Binary: (4+4W)*10*ComRate + W + 1 cycles.
  - Hex: (4+8W)*10*ComRate + W + 1 cycles.

## Test plan
- Header only: ComRate=8, Command=0x01, WordCount=0.
  - Tx carries 0x00, 0xAA, 0xFF, 0x01, each bit 8 clocks.
  - Done arrives 321 cycles after Start; Checksum=0x00000.
- Binary frame: Command=0x01, WordCount=1, WriteData=0x12345678.
  - Data characters are 0x12, 0x34, 0x56, 0x78.
  - Checksum=0x00114; Done pulses once.
- Hex frame: Command=0x81, WriteData=0xDEADBEEF.
  - Data characters are 0x44 0x45 0x41 0x44 0x42 0x45 0x45 0x46.
  - Checksum=0x00338.
- Backpressure: WordCount=2, WriteValid withheld 50 cycles in WaitWord.
  - Tx stays 1 and WriteReady stays 1 throughout the wait.
  - A Start pulse during the frame is ignored.
  - Exactly 8 data characters are sent in total.
- Reset: assert resetn=0 mid-way through bit 3 of 0xAA.
  - Tx=1 and Busy=0 immediately.
  - A following frame is transmitted bit-exact.
- Loopback: ComRate=217, Tx feeds the configuration loader in both modes, WordCount=3.
  - The loader emits 3 word strobes with identical words in order.
  - The loader's checksum equals Checksum.

Source files
------------

// File: rtl/config_uart_tx.sv
// config_uart_tx
//
// Serialises one configuration frame onto a UART line:
//   0x00, 0xAA, 0xFF, <command>, then WordCount 32-bit words.
// Each word goes out most significant byte first, either as four raw bytes
// (command bit 7 = 0) or as eight uppercase ASCII-hex characters
// (command bit 7 = 1, high nibble first). A 20-bit additive checksum of the
// data bytes is kept; header and command bytes do not contribute.
// Characters are 8N1: start bit 0, 8 data bits LSB first, stop bit 1, each
// bit held for COM_RATE clocks.
//
// Ports
//   i_clk          system clock, rising edge
//   i_resetn       asynchronous active-low reset
//   i_start        frame request, sampled only in Idle
//   i_command      command byte, latched on accepted start (bit 7 = hex mode)
//   i_word_count   number of data words, latched on accepted start
//   i_write_data   next data word
//   i_write_valid  i_write_data is valid
//   o_write_ready  block accepts a word this cycle
//   o_tx           serial line, idles high
//   o_busy         frame in progress
//   o_done         one-cycle pulse after the final stop bit
//   o_checksum     modulo-2^20 sum of data bytes of the current/last frame
//   o_state        frame FSM state, for observation
//
// Word handshake: a word transfers on a rising edge where o_write_ready and
// i_write_valid are both 1. o_write_ready is only raised in WaitWord and is
// registered, so it drops on the cycle after the transfer; i_write_valid is
// ignored whenever o_write_ready is 0.

module config_uart_tx #(
    parameter int unsigned COM_RATE = 217
) (
    input  logic        i_clk,
    input  logic        i_resetn,
    input  logic        i_start,
    input  logic [7:0]  i_command,
    input  logic [15:0] i_word_count,
    input  logic [31:0] i_write_data,
    input  logic        i_write_valid,
    output logic        o_write_ready,
    output logic        o_tx,
    output logic        o_busy,
    output logic        o_done,
    output logic [19:0] o_checksum,
    output logic [2:0]  o_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ID0    = 3'd1,
        S_IDAA   = 3'd2,
        S_IDFF   = 3'd3,
        S_CMD    = 3'd4,
        S_WAIT   = 3'd5,
        S_WORD   = 3'd6,
        S_FINISH = 3'd7
    } state_t;

    // The bit timer counts RELOAD..0, giving exactly COM_RATE clocks per bit.
    localparam logic [15:0] RELOAD = 16'(COM_RATE - 1);

    // Value driven on the line for bit slot idx of character c
    // (slot 0 = start, 1..8 = data LSB first, 9 = stop).
    function automatic logic bit_value(input logic [7:0] c, input logic [3:0] idx);
        logic [2:0] di;
        di = 3'(idx - 4'd1);
        if (idx == 4'd0)
            return 1'b0;
        else if (idx >= 4'd9)
            return 1'b1;
        else
            return c[di];
    endfunction

    // Byte idx of a word, 0 = most significant.
    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        if (nib < 4'd10)
            return 8'h30 + {4'h0, nib};
        else
            return 8'h37 + {4'h0, nib};
    endfunction

    // Character number num (0-based) of word w in the selected encoding.
    function automatic logic [7:0] char_for(input logic [31:0] w, input logic [2:0] num,
                                            input logic hex);
        logic [7:0] b;
        if (hex) begin
            b = byte_of(w, num[2:1]);
            return hex_char(num[0] ? b[3:0] : b[7:4]);
        end
        b = byte_of(w, num[1:0]);
        return b;
    endfunction

    // Registered state
    state_t      r_state;
    logic        r_tx;
    logic        r_busy;
    logic        r_done;
    logic        r_write_ready;
    logic [15:0] r_bit_cnt;
    logic [3:0]  r_bit_idx;
    logic [7:0]  r_char;
    logic [2:0]  r_char_num;
    logic [31:0] r_word;
    logic [15:0] r_words_left;
    logic [19:0] r_checksum;
    logic [7:0]  r_cmd;
    logic        r_hex;

    // Next-state values
    state_t      w_state;
    logic        w_tx;
    logic        w_busy;
    logic        w_done;
    logic        w_write_ready;
    logic [15:0] w_bit_cnt;
    logic [3:0]  w_bit_idx;
    logic [7:0]  w_char;
    logic [2:0]  w_char_num;
    logic [31:0] w_word;
    logic [15:0] w_words_left;
    logic [19:0] w_checksum;
    logic [7:0]  w_cmd;
    logic        w_hex;
    logic        w_load;
    logic [7:0]  w_load_char;

    // Helpers
    logic        w_sending;
    logic        w_bit_end;
    logic        w_char_end;
    logic        w_last_char;
    logic        w_byte_done;
    logic [7:0]  w_sum_byte;
    logic        w_handshake;
    logic [2:0]  w_next_num;

    assign w_sending   = (r_state == S_ID0) || (r_state == S_IDAA) || (r_state == S_IDFF) ||
                         (r_state == S_CMD) || (r_state == S_WORD);
    assign w_bit_end   = (r_bit_cnt == 16'd0);
    assign w_char_end  = w_bit_end && (r_bit_idx == 4'd9);
    assign w_last_char = r_hex ? (r_char_num == 3'd7) : (r_char_num == 3'd3);
    // In hex mode a byte is complete only after its low-nibble character.
    assign w_byte_done = !r_hex || r_char_num[0];
    assign w_sum_byte  = byte_of(r_word, r_hex ? r_char_num[2:1] : r_char_num[1:0]);
    assign w_handshake = r_write_ready && i_write_valid;
    assign w_next_num  = r_char_num + 3'd1;

    always_comb begin
        w_state       = r_state;
        w_tx          = r_tx;
        w_busy        = r_busy;
        w_done        = 1'b0;
        w_write_ready = 1'b0;
        w_bit_cnt     = r_bit_cnt;
        w_bit_idx     = r_bit_idx;
        w_char        = r_char;
        w_char_num    = r_char_num;
        w_word        = r_word;
        w_words_left  = r_words_left;
        w_checksum    = r_checksum;
        w_cmd         = r_cmd;
        w_hex         = r_hex;
        w_load        = 1'b0;
        w_load_char   = 8'h00;

        // Bit timing inside a character; the character-end step is handled
        // per state below.
        if (w_sending && !w_char_end) begin
            if (w_bit_end) begin
                w_bit_idx = r_bit_idx + 4'd1;
                w_tx      = bit_value(r_char, r_bit_idx + 4'd1);
                w_bit_cnt = RELOAD;
            end else begin
                w_bit_cnt = r_bit_cnt - 16'd1;
            end
        end

        case (r_state)
            S_IDLE: begin
                w_tx   = 1'b1;
                w_busy = 1'b0;
                if (i_start) begin
                    w_cmd        = i_command;
                    w_hex        = i_command[7];
                    w_words_left = i_word_count;
                    w_checksum   = 20'h00000;
                    w_busy       = 1'b1;
                    w_load       = 1'b1;
                    w_load_char  = 8'h00;
                    w_state      = S_ID0;
                end
            end
            S_ID0: begin
                if (w_char_end) begin
                    w_load      = 1'b1;
                    w_load_char = 8'hAA;
                    w_state     = S_IDAA;
                end
            end
            S_IDAA: begin
                if (w_char_end) begin
                    w_load      = 1'b1;
                    w_load_char = 8'hFF;
                    w_state     = S_IDFF;
                end
            end
            S_IDFF: begin
                if (w_char_end) begin
                    w_load      = 1'b1;
                    w_load_char = r_cmd;
                    w_state     = S_CMD;
                end
            end
            S_CMD: begin
                if (w_char_end) begin
                    w_tx = 1'b1;
                    if (r_words_left == 16'd0) begin
                        w_done  = 1'b1;
                        w_busy  = 1'b0;
                        w_state = S_FINISH;
                    end else begin
                        w_write_ready = 1'b1;
                        w_state       = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                w_tx          = 1'b1;
                w_write_ready = 1'b1;
                if (w_handshake) begin
                    w_write_ready = 1'b0;
                    w_word        = i_write_data;
                    w_words_left  = r_words_left - 16'd1;
                    w_char_num    = 3'd0;
                    w_load        = 1'b1;
                    w_load_char   = char_for(i_write_data, 3'd0, r_hex);
                    w_state       = S_WORD;
                end
            end
            S_WORD: begin
                if (w_char_end) begin
                    w_tx = 1'b1;
                    if (w_byte_done)
                        w_checksum = r_checksum + {12'h000, w_sum_byte};
                    if (!w_last_char) begin
                        w_char_num  = w_next_num;
                        w_load      = 1'b1;
                        w_load_char = char_for(r_word, w_next_num, r_hex);
                    end else if (r_words_left != 16'd0) begin
                        w_write_ready = 1'b1;
                        w_state       = S_WAIT;
                    end else begin
                        w_done  = 1'b1;
                        w_busy  = 1'b0;
                        w_state = S_FINISH;
                    end
                end
            end
            S_FINISH: begin
                w_tx    = 1'b1;
                w_busy  = 1'b0;
                w_state = S_IDLE;
            end
            default: begin
                w_tx    = 1'b1;
                w_busy  = 1'b0;
                w_state = S_IDLE;
            end
        endcase

        // A new character begins with its start bit on the next cycle.
        if (w_load) begin
            w_char    = w_load_char;
            w_bit_idx = 4'd0;
            w_bit_cnt = RELOAD;
            w_tx      = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state       <= S_IDLE;
            r_tx          <= 1'b1;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_write_ready <= 1'b0;
            r_bit_cnt     <= 16'd0;
            r_bit_idx     <= 4'd0;
            r_char        <= 8'h00;
            r_char_num    <= 3'd0;
            r_word        <= 32'h0000_0000;
            r_words_left  <= 16'd0;
            r_checksum    <= 20'h00000;
            r_cmd         <= 8'h00;
            r_hex         <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_tx          <= w_tx;
            r_busy        <= w_busy;
            r_done        <= w_done;
            r_write_ready <= w_write_ready;
            r_bit_cnt     <= w_bit_cnt;
            r_bit_idx     <= w_bit_idx;
            r_char        <= w_char;
            r_char_num    <= w_char_num;
            r_word        <= w_word;
            r_words_left  <= w_words_left;
            r_checksum    <= w_checksum;
            r_cmd         <= w_cmd;
            r_hex         <= w_hex;
        end
    end

    assign o_tx          = r_tx;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_write_ready = r_write_ready;
    assign o_checksum    = r_checksum;
    assign o_state       = r_state;

endmodule
